// File: rtl/competition_hazard_pkg.sv
// Shared defaults and helpers for the competition_hazard flag generator.
//   CH_SYNC_STAGES_DEF : default synchroniser depth per input
//   CH_FILTER_CNT_DEF  : default number of consecutive differing cycles before flag toggles
//   ch_cnt_w(n)        : width of a counter able to hold 0..n
package competition_hazard_pkg;

  localparam int CH_SYNC_STAGES_DEF = 2;
  localparam int CH_FILTER_CNT_DEF  = 2;

  function automatic int ch_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ch_sync.sv
// ch_sync: N-stage single-bit synchroniser for an input asynchronous to clk.
// Ports:
//   clk   : input clock, rising edge
//   rst_n : synchronous active-low reset, clears every stage to 0
//   d     : asynchronous input bit
//   q     : synchronised output (last stage of the chain)
// Parameters:
//   SYNC_STAGES : chain depth, must be >= 2
module ch_sync
  import competition_hazard_pkg::*;
#(
  parameter int SYNC_STAGES = CH_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // bit 0 captures the raw input; the top bit is the settled copy
  logic [SYNC_STAGES-1:0] sync_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p0[SYNC_STAGES-1];

endmodule

// File: rtl/competition_hazard.sv
// competition_hazard: glitch-safe AND detector for two asynchronous controls.
// Each input is resynchronised, their AND is digitally filtered, and flag is a
// registered level that only moves after the AND has held a new value for
// FILTER_CNT consecutive cycles. Latency from a stable input change to flag is
// SYNC_STAGES + FILTER_CNT cycles, symmetric for rise and fall.
// Ports:
//   clk      : input clock, rising edge
//   rst_n    : synchronous active-low reset
//   en       : enable, asynchronous to clk
//   din_rvs  : data/reverse qualifier, asynchronous to clk
//   flag     : registered, filtered en AND din_rvs
//   flag_raw : (only with COMPETITION_HAZARD_RAW_FLAG_EN) unsynchronised
//              combinational en AND din_rvs, hazard-prone, debug only
// Parameters:
//   SYNC_STAGES : synchroniser depth (>= 2)
//   FILTER_CNT  : consecutive differing cycles needed to toggle flag (>= 1)
// Configuration macro: COMPETITION_HAZARD_RAW_FLAG_EN
module competition_hazard
  import competition_hazard_pkg::*;
#(
  parameter int SYNC_STAGES = CH_SYNC_STAGES_DEF,
  parameter int FILTER_CNT  = CH_FILTER_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din_rvs,
`ifdef COMPETITION_HAZARD_RAW_FLAG_EN
  output logic flag_raw,
`endif
  output logic flag
);

  localparam int CNT_W = ch_cnt_w(FILTER_CNT);

  logic             en_s;
  logic             din_s;
  logic             cond_p0;
  logic [CNT_W-1:0] cnt_p1;

  // The count reaching FILTER_CNT-1 means this cycle is the last differing one
  // needed, so cnt never gets past FILTER_CNT-1.
  function automatic logic cnt_at_limit(input logic [CNT_W-1:0] c);
    return c == CNT_W'(FILTER_CNT - 1);
  endfunction

  // ---- stage 0: resynchronise both inputs ----
  ch_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (en),
    .q     (en_s)
  );

  ch_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din_rvs),
    .q     (din_s)
  );

  // cond only feeds flop D inputs below; it is never routed out.
  assign cond_p0 = en_s & din_s;

  // ---- stage 1: filter counter and flag register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
      flag   <= 1'b0;
    end else if (cond_p0 == flag) begin
      // agreement wipes any partial count: no memory of earlier near-misses
      cnt_p1 <= '0;
    end else if (cnt_at_limit(cnt_p1)) begin
      flag   <= cond_p0;
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

`ifdef COMPETITION_HAZARD_RAW_FLAG_EN
  // Deliberately unsynchronised: shows the race glitch the filtered flag hides.
  assign flag_raw = en & din_rvs;
`endif

endmodule

// File: tb/tb_competition_hazard.sv
// Bench for competition_hazard: one default instance (2 sync stages, filter 2)
// and one swept instance (3 sync stages, filter 4) share the same stimulus.
// A per-cycle scoreboard compares both flags against a window-based model;
// directed checks cover reset hold, latency, race, short pulses, mid-count reset.
module tb_competition_hazard;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic din_rvs;
  logic flag0;
  logic flag1;
`ifdef COMPETITION_HAZARD_RAW_FLAG_EN
  logic flag_raw0;
  logic flag_raw1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bit exp0_q[$];
  bit exp1_q[$];

  always #5 clk = ~clk;

  competition_hazard dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din_rvs  (din_rvs),
`ifdef COMPETITION_HAZARD_RAW_FLAG_EN
    .flag_raw (flag_raw0),
`endif
    .flag     (flag0)
  );

  competition_hazard #(.SYNC_STAGES(3), .FILTER_CNT(4)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din_rvs  (din_rvs),
`ifdef COMPETITION_HAZARD_RAW_FLAG_EN
    .flag_raw (flag_raw1),
`endif
    .flag     (flag1)
  );

  task automatic chk_val(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the AND sampled at edge j reaches the filter S edges later; flag
  // toggles once the last F filter inputs all differ from the current flag.
  function automatic void mstep(input int s_n, input int f_n, input bit smp,
                                input bit rst_ok, inout bit [31:0] sh,
                                inout bit [31:0] ch, inout bit fl);
    bit [31:0] m;
    bit        c;
    if (!rst_ok) begin
      sh = '0;
      ch = '0;
      fl = 1'b0;
    end else begin
      c  = sh[s_n-1];
      sh = {sh[30:0], smp};
      ch = {ch[30:0], c};
      m  = (32'h1 << f_n) - 32'h1;
      if (((ch ^ {32{fl}}) & m) == m) fl = ~fl;
    end
  endfunction

  bit [31:0] sh0 = '0, ch0 = '0, sh1 = '0, ch1 = '0;
  bit        fl0 = 1'b0, fl1 = 1'b0;

  initial begin : scoreboard
    bit s;
    bit r;
    forever begin
      @(posedge clk);
      s = en & din_rvs;
      r = rst_n;
      mstep(2, 2, s, r, sh0, ch0, fl0);
      mstep(3, 4, s, r, sh1, ch1, fl1);
      exp0_q.push_back(fl0);
      exp1_q.push_back(fl1);
      @(negedge clk);
      chk_val("sb_flag_s2f2", flag0, exp0_q.pop_front());
      chk_val("sb_flag_s3f4", flag1, exp1_q.pop_front());
    end
  end

  // Inputs were changed on a negedge; check flags edge by edge afterwards.
  task automatic latency_check(input logic v);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 3) chk_val("lat_pre_s2f2", flag0, ~v);
      if (i == 4) chk_val("lat_s2f2", flag0, v);
      if (i == 6) chk_val("lat_pre_s3f4", flag1, ~v);
      if (i == 7) chk_val("lat_s3f4", flag1, v);
    end
  endtask

  task automatic pulse(input int len, input bit seen0_exp, input bit seen1_exp);
    bit seen0 = 1'b0;
    bit seen1 = 1'b0;
    @(negedge clk);
    en      = 1'b1;
    din_rvs = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == len - 1) din_rvs = 1'b0;
      if (flag0 === 1'b1) seen0 = 1'b1;
      if (flag1 === 1'b1) seen1 = 1'b1;
    end
    en = 1'b0;
    chk_val($sformatf("pulse%0d_s2f2", len), seen0, seen0_exp);
    chk_val($sformatf("pulse%0d_s3f4", len), seen1, seen1_exp);
  endtask

  initial begin : stim
    // reset hold with both inputs high
    rst_n   = 1'b0;
    en      = 1'b1;
    din_rvs = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_val("rst_s2f2", flag0, 1'b0);
      chk_val("rst_s3f4", flag1, 1'b0);
`ifdef COMPETITION_HAZARD_RAW_FLAG_EN
      chk_val("rst_raw", flag_raw0, 1'b1);
`endif
    end

    // steady assert, then deassert din_rvs
    rst_n = 1'b1;
    latency_check(1'b1);
    repeat (3) @(negedge clk);
    din_rvs = 1'b0;
    latency_check(1'b0);
    repeat (4) @(negedge clk);

    // race: en rises 1 ns before an edge, din_rvs falls on that edge
    en      = 1'b0;
    din_rvs = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #9 en = 1'b1;
    #1 din_rvs = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flag0 !== 1'b0 || i == 99) chk_val("race_s2f2", flag0, 1'b0);
      if (flag1 !== 1'b0 || i == 99) chk_val("race_s3f4", flag1, 1'b0);
    end
    en = 1'b0;
    repeat (4) @(negedge clk);

    // short pulses: the swept instance needs 4 cycles, the default 2
    pulse(1, 1'b0, 1'b0);
    pulse(2, 1'b1, 1'b0);
    pulse(3, 1'b1, 1'b0);
    pulse(4, 1'b1, 1'b1);

    // mid-count reset
    @(negedge clk);
    en      = 1'b1;
    din_rvs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_val("midrst_s2f2", flag0, 1'b0);
    chk_val("midrst_s3f4", flag1, 1'b0);
    rst_n = 1'b1;
    latency_check(1'b1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
